// File: rtl/main_run_ctrl.sv
`default_nettype none
// =============================================================================
// main_run_ctrl : preloads main's memories, runs it once, times it, checks result
// Revision 1.0
// =============================================================================
module main_run_ctrl #(
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 32,
    parameter int SIZE_W         = 6,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run_go,
    input  logic                  skip_load,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_W-1:0]     ld_addr,
    input  logic [DATA_W-1:0]     ld_data,
    input  logic                  ld_last,
    input  logic [31:0]           exp_return,
    output logic                  start_port,
    input  logic                  done_port,
    input  logic [31:0]           return_port,
    output logic [1:0]            S_oe_ram,
    output logic [1:0]            S_we_ram,
    output logic [2*ADDR_W-1:0]   S_addr_ram,
    output logic [2*DATA_W-1:0]   S_Wdata_ram,
    output logic [2*SIZE_W-1:0]   S_data_ram_size,
    input  logic [1:0]            Sout_DataRdy,
    output logic                  busy,
    output logic                  result_valid,
    input  logic                  result_ack,
    output logic                  result_pass,
    output logic                  result_timeout,
    output logic [31:0]           result_return,
    output logic [CNT_W-1:0]      result_cycles
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WR    = 3'd2,
        ST_START = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5,
        ST_TOUT  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYCLES);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic                start_q, start_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         ret_q, ret_d;
    logic [CNT_W-1:0]    cyc_q, cyc_d;
    logic                pass_q, pass_d;
    logic                tmo_q, tmo_d;

    logic                unused_rdy1;
    assign unused_rdy1 = Sout_DataRdy[1];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ret_d   = ret_q;
        cyc_d   = cyc_q;
        pass_d  = pass_q;
        tmo_d   = tmo_q;

        case (state_q)
            ST_IDLE: begin
                if (run_go) begin
                    state_d = skip_load ? ST_START : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    addr_d  = ld_addr;
                    data_d  = ld_data;
                    last_d  = ld_last;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (Sout_DataRdy[0]) begin
                    state_d = last_q ? ST_START : ST_LOAD;
                end
            end
            ST_START: begin
                cnt_d = CNT_ONE;
                if (done_port) begin
                    ret_d   = return_port;
                    cyc_d   = CNT_ONE;
                    pass_d  = (return_port == exp_return);
                    tmo_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_d = sat_inc(cnt_q);
                // done takes priority over a timeout landing on the same cycle
                if (done_port) begin
                    ret_d   = return_port;
                    cyc_d   = sat_inc(cnt_q);
                    pass_d  = (return_port == exp_return);
                    tmo_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q >= TMO_LIM) begin
                    cyc_d   = TMO_LIM;
                    pass_d  = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = ST_TOUT;
                end
            end
            ST_DONE, ST_TOUT: begin
                if (result_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // outputs to main are registered from the upcoming state
        we_d    = (state_d == ST_WR);
        start_d = (state_d == ST_START);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            start_q <= 1'b0;
            cnt_q   <= '0;
            ret_q   <= '0;
            cyc_q   <= '0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            last_q  <= last_d;
            we_q    <= we_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
            cyc_q   <= cyc_d;
            pass_q  <= pass_d;
            tmo_q   <= tmo_d;
        end
    end

    assign ld_ready        = (state_q == ST_LOAD);
    assign busy            = (state_q != ST_IDLE);
    assign result_valid    = (state_q == ST_DONE) || (state_q == ST_TOUT);
    assign result_pass     = pass_q;
    assign result_timeout  = tmo_q;
    assign result_return   = ret_q;
    assign result_cycles   = cyc_q;

    assign start_port      = start_q;
    assign S_oe_ram        = 2'b00;
    assign S_we_ram        = {1'b0, we_q};
    assign S_addr_ram      = {{ADDR_W{1'b0}}, addr_q};
    assign S_Wdata_ram     = {{DATA_W{1'b0}}, data_q};
    assign S_data_ram_size = {{SIZE_W{1'b0}}, SIZE_W'(32)};

endmodule
`default_nettype wire

// File: tb/tb_main_run_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for main_run_ctrl with a small behavioural stand-in for main.
module tb_main_run_ctrl;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int SW  = 6;
    localparam int CW  = 32;
    localparam int TMO = 16;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            run_go = 1'b0, skip_load = 1'b0;
    logic            ld_valid = 1'b0, ld_last = 1'b0;
    logic [AW-1:0]   ld_addr = '0;
    logic [DW-1:0]   ld_data = '0;
    logic [31:0]     exp_return = '0;
    logic            done_port = 1'b0;
    logic [31:0]     return_port = '0;
    logic [1:0]      Sout_DataRdy = 2'b00;
    logic            result_ack = 1'b0;

    logic            ld_ready, start_port, busy, result_valid, result_pass, result_timeout;
    logic [1:0]      S_oe_ram, S_we_ram;
    logic [2*AW-1:0] S_addr_ram;
    logic [2*DW-1:0] S_Wdata_ram;
    logic [2*SW-1:0] S_data_ram_size;
    logic [31:0]     result_return;
    logic [CW-1:0]   result_cycles;

    main_run_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .CNT_W(CW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock(clock), .reset(reset), .run_go(run_go), .skip_load(skip_load),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_last(ld_last), .exp_return(exp_return), .start_port(start_port),
        .done_port(done_port), .return_port(return_port), .S_oe_ram(S_oe_ram),
        .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram), .S_Wdata_ram(S_Wdata_ram),
        .S_data_ram_size(S_data_ram_size), .Sout_DataRdy(Sout_DataRdy), .busy(busy),
        .result_valid(result_valid), .result_ack(result_ack), .result_pass(result_pass),
        .result_timeout(result_timeout), .result_return(result_return),
        .result_cycles(result_cycles)
    );

    always #5 clock = ~clock;

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct { bit pass; bit tmo; logic [31:0] ret; logic [CW-1:0] cyc; } res_t;

    wr_t  exp_wr[$];
    res_t exp_res[$];
    wr_t  load_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int ack_lat    = 2;
    int done_delay = -1;
    logic [31:0] main_ret = '0;
    int starts_seen = 0;
    int starts_exp  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // main stand-in: write acknowledge after ack_lat strobe cycles
    int we_cnt = 0;
    always @(negedge clock) begin
        if (S_we_ram[0]) begin
            we_cnt++;
            Sout_DataRdy = {1'b0, (we_cnt >= ack_lat)};
        end else begin
            we_cnt = 0;
            Sout_DataRdy = 2'b00;
        end
    end

    // main stand-in: done_delay cycles after the start_port cycle, pulse done
    bit run_on = 0;
    int rc = 0;
    always @(negedge clock) begin
        done_port   = 1'b0;
        return_port = $urandom;
        if (start_port) begin
            run_on = 1;
            rc = 0;
        end else if (run_on) begin
            rc++;
        end
        if (run_on && done_delay >= 0 && rc == done_delay) begin
            done_port   = 1'b1;
            return_port = main_ret;
            run_on      = 0;
        end
        if (!reset) run_on = 0;
    end

    // write monitor
    bit  prev_we = 0;
    wr_t got_w;
    always @(negedge clock) begin
        if (S_we_ram[0] && !prev_we) begin
            if (exp_wr.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL extra_write: got write addr 0x%0h data 0x%0h, expected none",
                         S_addr_ram, S_Wdata_ram);
            end else begin
                got_w = exp_wr.pop_front();
                chk("wr_addr", 64'(S_addr_ram), 64'(got_w.a));
                chk("wr_data", S_Wdata_ram, 64'(got_w.d));
                chk("wr_size", 64'(S_data_ram_size), 64'(32));
                chk("wr_oe", 64'(S_oe_ram), 64'(0));
            end
        end
        prev_we = S_we_ram[0];
    end

    // start_port monitor
    int start_w = 0;
    always @(negedge clock) begin
        if (start_port) begin
            if (start_w == 0) begin
                starts_seen++;
                chk("writes_pending_at_start", 64'(exp_wr.size()), 64'(0));
            end
            start_w++;
        end else if (start_w > 0) begin
            chk("start_width", 64'(start_w), 64'(1));
            start_w = 0;
        end
    end

    // result monitor
    bit   prev_rv = 0;
    res_t got_r;
    always @(negedge clock) begin
        if (result_valid && !prev_rv) begin
            if (exp_res.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL extra_result: got result_valid, expected none");
            end else begin
                got_r = exp_res.pop_front();
                chk("res_timeout", 64'(result_timeout), 64'(got_r.tmo));
                chk("res_pass", 64'(result_pass), 64'(got_r.pass));
                chk("res_cycles", 64'(result_cycles), 64'(got_r.cyc));
                chk("res_busy", 64'(busy), 64'(1));
                if (!got_r.tmo) chk("res_return", 64'(result_return), 64'(got_r.ret));
            end
        end
        prev_rv = result_valid;
    end

    task automatic run_case(input bit skip, input int lat, input int dd,
                            input logic [31:0] ret, input logic [31:0] expv, input bit noise);
        res_t r;
        int   guard;
        ack_lat    = lat;
        done_delay = dd;
        main_ret   = ret;
        exp_return = expv;
        if (!skip) foreach (load_q[i]) exp_wr.push_back(load_q[i]);
        if (dd >= 0 && dd <= TMO) begin
            r.tmo = 0; r.pass = (ret == expv); r.ret = ret; r.cyc = CW'(dd + 1);
        end else begin
            r.tmo = 1; r.pass = 0; r.ret = '0; r.cyc = CW'(TMO);
        end
        exp_res.push_back(r);
        starts_exp++;

        @(negedge clock); run_go = 1'b1; skip_load = skip;
        @(negedge clock); run_go = 1'b0; skip_load = 1'b0;
        if (!skip) begin
            foreach (load_q[i]) begin
                repeat ($urandom_range(0, 2)) @(negedge clock);
                ld_valid = 1'b1;
                ld_addr  = load_q[i].a;
                ld_data  = load_q[i].d;
                ld_last  = (i == load_q.size() - 1);
                guard = 0;
                while (!ld_ready && guard < 200) begin
                    @(negedge clock);
                    guard++;
                end
                if (guard >= 200) chk("ld_ready_wait", 64'(ld_ready), 64'(1));
                @(negedge clock);
                ld_valid = 1'b0; ld_last = 1'b0;
                ld_addr  = AW'($urandom); ld_data = $urandom;
            end
        end
        guard = 0;
        while (!result_valid && guard < 500) begin
            if (noise) begin
                run_go    = 1'($urandom_range(0, 1));
                skip_load = 1'($urandom_range(0, 1));
                ld_valid  = 1'($urandom_range(0, 1));
                ld_last   = 1'($urandom_range(0, 1));
                ld_addr   = AW'($urandom);
                ld_data   = $urandom;
            end
            @(negedge clock);
            guard++;
        end
        run_go = 1'b0; skip_load = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
        if (guard >= 500) chk("result_valid_wait", 64'(result_valid), 64'(1));
        repeat ($urandom_range(0, 2)) @(negedge clock);
        result_ack = 1'b1;
        @(negedge clock);
        result_ack = 1'b0;
        chk("valid_after_ack", 64'(result_valid), 64'(0));
        chk("busy_after_ack", 64'(busy), 64'(0));
        chk("cycles_held", 64'(result_cycles), 64'(r.cyc));
    endtask

    function automatic wr_t mk(input int a, input logic [31:0] d);
        wr_t w;
        w.a = AW'(a);
        w.d = d;
        return w;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        repeat (3) @(negedge clock);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_valid", 64'(result_valid), 64'(0));
        chk("rst_ld_ready", 64'(ld_ready), 64'(0));
        chk("rst_start", 64'(start_port), 64'(0));
        chk("rst_we", 64'(S_we_ram), 64'(0));
        chk("rst_oe", 64'(S_oe_ram), 64'(0));
        chk("rst_addr", 64'(S_addr_ram), 64'(0));
        chk("rst_wdata", S_Wdata_ram, 64'(0));
        chk("rst_size", 64'(S_data_ram_size), 64'(32));
        chk("rst_results", {result_pass, result_timeout, result_return, 30'(result_cycles)}, 64'(0));
        reset = 1'b1;
        @(negedge clock);

        load_q = '{mk(12'h004, 32'hDEADBEEF), mk(12'h008, 32'h1), mk(12'h00C, 32'h2)};
        run_case(0, 2, 3, 32'h7, 32'h7, 0);
        run_case(1, 2, 5, 32'h2A, 32'h2A, 0);
        run_case(1, 2, 5, 32'h2A, 32'h2B, 0);
        run_case(1, 2, -1, 32'h1, 32'h1, 0);
        run_case(1, 2, TMO, 32'h55, 32'h55, 0);
        run_case(1, 2, TMO + 1, 32'h55, 32'h55, 0);
        run_case(1, 2, 0, 32'h9, 32'h9, 0);

        // reset while a write is stalled waiting for DataRdy
        load_q = '{mk(12'h020, 32'h12345678)};
        ack_lat = 1000;
        exp_wr.push_back(load_q[0]);
        @(negedge clock); run_go = 1'b1;
        @(negedge clock); run_go = 1'b0;
        ld_valid = 1'b1; ld_addr = load_q[0].a; ld_data = load_q[0].d; ld_last = 1'b0;
        guard = 0;
        while (!ld_ready && guard < 50) begin @(negedge clock); guard++; end
        @(negedge clock);
        ld_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("we_stalled", 64'(S_we_ram), 64'(1));
        #2 reset = 1'b0;
        #1;
        chk("abort_we", 64'(S_we_ram), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_valid", 64'(result_valid), 64'(0));
        @(negedge clock);
        reset = 1'b1;

        load_q = '{mk(12'h040, 32'hCAFEF00D), mk(12'h044, 32'h0BADBEEF)};
        run_case(0, 1, 10, 32'h3, 32'h3, 1);
        run_case(1, 2, 12, 32'h4, 32'h5, 1);

        for (int n = 0; n < 14; n++) begin
            int nw;
            int dd;
            logic [31:0] rv;
            nw = $urandom_range(1, 4);
            load_q.delete();
            for (int k = 0; k < nw; k++) load_q.push_back(mk($urandom_range(0, 255) * 4, $urandom));
            dd = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 20));
            rv = $urandom;
            run_case(($urandom_range(0, 3) == 0), $urandom_range(1, 3), dd, rv,
                     ($urandom_range(0, 1) == 1) ? rv : $urandom, 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clock);
        chk("start_count", 64'(starts_seen), 64'(starts_exp));
        chk("writes_left", 64'(exp_wr.size()), 64'(0));
        chk("results_left", 64'(exp_res.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/main_run_ctrl.md
Name: main_run_ctrl

Overview:
- Synthesizable run controller sitting directly upstream of the HLS-generated `main` core.
- Preloads `main`'s internal memories through the slave RAM port (channel 0) from a host load stream.
- Then pulses `start_port`, counts cycles until `done_port`, and captures `return_port`.
- Compares the captured value against an expected value and reports pass/fail/timeout, giving the on-board equivalent of the simulation harness.

Parameters:
- ADDR_W, 10, per-channel slave address width.
- DATA_W, 32, per-channel slave data width.
- SIZE_W, 6, per-channel data-size field width.
- CNT_W, 32, cycle counter width.
- TIMEOUT_CYCLES, 200000000, run-cycle limit before abort.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- run_go  in  1  one-cycle request to begin a run; honoured only in IDLE.
- skip_load  in  1  sampled with run_go; 1 = go straight to START.
- ld_valid  in  1  load word valid.
- ld_ready  out  1  load word accepted (high only in LOAD).
- ld_addr  in  ADDR_W  target byte address in `main` memory space.
- ld_data  in  DATA_W  word to write.
- ld_last  in  1  final load word.
- exp_return  in  32  expected return value, sampled on done_port.
- start_port  out  1  to main.start_port.
- done_port  in  1  from main.done_port.
- return_port  in  32  from main.return_port.
- S_oe_ram  out  2  to main; constant 0.
- S_we_ram  out  2  to main; bit0 write strobe, bit1 = 0.
- S_addr_ram  out  2*ADDR_W  channel0 in [ADDR_W-1:0]; channel1 = 0.
- S_Wdata_ram  out  2*DATA_W  channel0 in the low half; channel1 = 0.
- S_data_ram_size  out  2*SIZE_W  channel0 = 32; channel1 = 0.
- Sout_DataRdy  in  2  from main; bit0 = write acknowledge.
- busy  out  1  state != IDLE.
- result_valid  out  1  high in DONE or TIMEOUT.
- result_ack  in  1  releases the result and returns to IDLE.
- result_pass  out  1  return matched exp_return.
- result_timeout  out  1  run aborted on timeout.
- result_return  out  32  captured return_port.
- result_cycles  out  CNT_W  cycles from start to done, inclusive.

Behaviour:
- Reset (reset=0, async): state=IDLE; every output 0, except S_data_ram_size, whose channel0 field is constant 32. Counters and result registers cleared.
- All outputs to `main` are registered.
- IDLE:
  - run_go=1 and skip_load=0 -> LOAD.
  - run_go=1 and skip_load=1 -> START.
  - run_go outside IDLE is ignored.
- LOAD:
  - ld_ready=1.
  - On ld_valid&ld_ready, latch addr/data/last -> WR.
  - ld_valid is ignored in every other state, since ld_ready=0 there.
- WR:
  - Drive S_we_ram[0]=1, address, data and size=32.
  - Hold these until Sout_DataRdy[0]=1 in the same cycle.
  - Then drop the strobe next cycle; go to START if last, else LOAD. One word per WR visit; no pipelining.
- START:
  - start_port=1 for exactly one cycle; cycle counter loaded with 1 -> RUN.
  - If done_port=1 already in this cycle: capture with cycles=1 -> DONE.
- RUN:
  - Counter increments each cycle.
  - On done_port=1:
    - result_return <= return_port.
    - result_cycles <= counter+1.
    - result_pass <= (return_port==exp_return).
    - Go to DONE.
  - If counter reaches TIMEOUT_CYCLES without done: result_timeout=1, result_pass=0, result_cycles=TIMEOUT_CYCLES -> TIMEOUT.
  - done_port and timeout in the same cycle: done wins.
- DONE / TIMEOUT:
  - result_valid=1; results are stable.
  - result_ack -> IDLE, with result_valid cleared in the same transition. Result data is held until the next capture.
- Counter saturates at its maximum; it does not wrap.
- A reset asserted mid-operation (including mid-WR) aborts immediately. The strobe drops asynchronously and no partial result is produced.
- No write timeout: a missing DataRdy stalls in WR indefinitely; busy stays high.

Test Plan:
- run_go with skip_load=0; 3 words (0x004->0xDEADBEEF, 0x008->0x1, 0x00C->0x2, last on the third); main acks each in 2 cycles -> 3 write strobes with exact addr/data, size field 32, then one-cycle start_port.
- skip_load=1; done_port 5 cycles after start_port with return 0x2A and exp_return 0x2A -> result_valid, pass=1, return=0x2A, cycles=6.
- Same as the previous case but exp_return=0x2B -> pass=0, return=0x2A.
- TIMEOUT_CYCLES=16; done never asserted -> TIMEOUT after 16 run cycles, timeout=1, pass=0, cycles=16. A run whose done lands on the exact timeout cycle reports DONE instead.
- reset deasserted→asserted while in WR -> S_we_ram=0 at once, busy=0. A fresh run afterwards completes normally.
- run_go pulses while busy, and ld_valid asserted in RUN -> ignored: no state change and no extra writes.
